rab_buffer_arbiter: RTL



---
 rtl/rab_buffer_arbiter_if.sv | 34 +++
 rtl/rab_buffer_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/rab_buffer_arbiter_if.sv
// Requester/buffer bus for the shared-buffer arbiter: NUM_IN beat requesters
// on one side, the buffer upstream port and flush handshake on the other.
interface rab_buffer_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IN     = 4,
    parameter int ID_WIDTH   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]            in_last;
    logic [NUM_IN-1:0]            in_ready;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [ID_WIDTH-1:0]          out_id;
    logic                         out_last;
    logic                         out_ready;
    logic                         buf_almost_full;
    logic                         flush_req;
    logic                         flush_entries;
    logic                         flush_ack;
    logic                         busy;

    modport master (
        output in_valid, in_data, in_last, out_ready, buf_almost_full, flush_req,
        input  in_ready, out_valid, out_data, out_id, out_last,
               flush_entries, flush_ack, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready, buf_almost_full, flush_req,
        output in_ready, out_valid, out_data, out_id, out_last,
               flush_entries, flush_ack, busy
    );
endinterface

// File: rtl/rab_buffer_arbiter.sv
// Round-robin burst arbiter in front of a shared buffer: a granted requester
// keeps the port until its last beat, and flush requests wait for burst end.
module rab_buffer_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IN     = 4,
    parameter int ID_WIDTH   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    rab_buffer_arbiter_if.slave   bus
);
    // state  | meaning
    // IDLE   | arbitrate combinationally among valid requesters from rr_ptr
    // LOCKED | burst in progress, only the registered grant is passed
    // FLUSH  | single-cycle flush strobe and acknowledge to the buffer
    typedef enum logic [1:0] {IDLE = 2'd0, LOCKED = 2'd1, FLUSH = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [ID_WIDTH-1:0] grant, grant_nxt;
    logic                flush_pend, flush_pend_nxt;

    logic [ID_WIDTH-1:0] cand, idx, sel, sel_inc;
    logic                cand_found, idle_ok, active, xfer, sel_last;

    // Scan downward so the lowest cyclic offset from rr_ptr wins.
    always_comb begin
        cand       = '0;
        idx        = '0;
        cand_found = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_IN);
            if (bus.in_valid[idx]) begin
                cand       = idx;
                cand_found = 1'b1;
            end
        end
    end

    assign sel      = (state == LOCKED) ? grant : cand;
    assign idle_ok  = cand_found && !bus.buf_almost_full && !bus.flush_req;
    assign active   = rstn && (((state == IDLE) && idle_ok) || (state == LOCKED));
    assign sel_last = bus.in_last[sel];
    assign xfer     = active && bus.in_valid[sel] && bus.out_ready;
    assign sel_inc  = (sel == ID_WIDTH'(NUM_IN - 1)) ? '0 : sel + ID_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            grant      <= grant_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        grant_nxt      = grant;
        flush_pend_nxt = flush_pend;
        case (state)
            IDLE: begin
                if (bus.flush_req) begin
                    state_nxt = FLUSH;
                end else if (xfer && !sel_last) begin
                    state_nxt = LOCKED;
                    grant_nxt = sel;
                end else if (xfer) begin
                    rr_ptr_nxt = sel_inc;
                end
            end
            LOCKED: begin
                // A flush seen mid-burst is remembered even if the request drops.
                if (bus.flush_req) flush_pend_nxt = 1'b1;
                if (xfer && sel_last) begin
                    rr_ptr_nxt     = sel_inc;
                    state_nxt      = (flush_pend || bus.flush_req) ? FLUSH : IDLE;
                    flush_pend_nxt = 1'b0;
                end
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == ID_WIDTH'(i)) bus.out_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        bus.out_valid = active && bus.in_valid[sel];
        bus.out_id    = active ? sel : '0;
        bus.out_last  = active && sel_last;
        bus.in_ready  = '0;
        if (active) bus.in_ready[sel] = bus.out_ready;
        bus.flush_entries = rstn && (state == FLUSH);
        bus.flush_ack     = rstn && (state == FLUSH);
        bus.busy          = rstn && (state != IDLE);
    end
endmodule
